adv7513_i2c_arbiter: RTL and testbench
======================================

// Module: adv7513_i2c_arbiter
// PURPOSE
//  Shares one i2c_master instance among NUM_REQ requesters (ADV7513 init sequencer, register-read debug, HPD poller).
//  Round-robin arbitration, one I2C transaction per grant; issues the master's write_en/read_en strobe and tracks busy.
//  Returns read data and status, then enforces an inter-transaction gap.
//  Sits between the requester FSMs and i2c_master; the SDA/SCL tristate stays in the top level.
// PARAMETERS
//  NUM_REQ        3         number of requesters, 2..8
//  TXN_GAP        0         idle clk cycles after each transaction before the next grant, 0..65535
//  TIMEOUT_CYCLES 50000000  watchdog limit in S_WAIT (used only with ADV7513_I2C_ARB_TIMEOUT_EN)
// PORTS
//  clk           in   1          system clock
//  reset         in   1          synchronous, active-low
//  req           in   NUM_REQ    request; held high until the matching ack
//  rnw           in   NUM_REQ    1=read, 0=write; sampled at grant
//  chip_addr_in  in   7*NUM_REQ  per-requester 7-bit chip address (requester i at [7i+:7])
//  reg_addr_in   in   8*NUM_REQ  per-requester register address
//  wdata_in      in   8*NUM_REQ  per-requester write data
//  gnt           out  NUM_REQ    one-hot; high from grant through ack cycle
//  ack           out  NUM_REQ    1-cycle completion pulse to the granted requester
//  rdata         out  8          read data, valid in the ack cycle and held until the next ack
//  status        out  3          i2c_master status latched at completion
//  timeout_err   out  1          1-cycle pulse on watchdog abort (tied 0 without the macro)
//  m_chip_addr   out  7          to i2c_master chip_addr
//  m_reg_addr    out  8          to i2c_master reg_addr
//  m_data_in     out  8          to i2c_master data_in
//  m_write_en    out  1          1-cycle write strobe
//  m_read_en     out  1          1-cycle read strobe
//  m_busy        in   1          i2c_master busy
//  m_data_out    in   8          i2c_master data_out
//  m_status      in   3          i2c_master status
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - all outputs are 0; state is S_IDLE; rr_ptr=NUM_REQ-1; gap counter is 0.
//   - Reset mid-transaction drops the grant without an ack; the requester must re-request.
//  S_IDLE:
//   - If req!=0, pick the first set bit scanning upward from rr_ptr+1 (mod NUM_REQ).
//   - Set gnt; latch rnw, chip_addr, reg_addr and wdata into m_* registers; go to S_ISSUE.
//   - If req==0, stay in S_IDLE.
//  S_ISSUE: pulse m_read_en (rnw=1) or m_write_en (rnw=0) for exactly 1 cycle; go to S_WAIT.
//  S_WAIT:
//   - Stay while the strobe is still registered high or m_busy==1.
//   - Otherwise go to S_DONE. This covers busy rising 1 cycle late.
//  S_DONE:
//   - ack[g]=1 for 1 cycle; rdata<=m_data_out on reads only (writes leave rdata unchanged); status<=m_status.
//   - Set rr_ptr=g. If TXN_GAP==0 go to S_IDLE, else go to S_GAP.
//  S_GAP: count TXN_GAP cycles, then go to S_IDLE. gnt goes low on leaving S_DONE.
//  Latency:
//   - req to strobe is 2 cycles (IDLE, ISSUE); done to ack is 1 cycle.
//   - Minimum back-to-back spacing is TXN_GAP+1 idle cycles.
//  Ordering and fairness:
//   - Simultaneous requests are served in rotating order; no requester waits more than NUM_REQ-1 transactions.
//   - req dropping after grant does not abort; the transaction completes and ack still pulses.
//   - Inputs changing after grant have no effect; the m_* registers hold until the next grant.
//   - Never two strobes per grant; m_write_en and m_read_en are never both high.
// CONFIGURATION
//  ADV7513_I2C_ARB_TIMEOUT_EN defined:
//   - A 26-bit counter runs in S_WAIT.
//   - On reaching TIMEOUT_CYCLES: pulse timeout_err, set status=3'b111, pulse ack to the granted requester, go to S_GAP.
//   - rdata is unchanged on timeout.
//  ADV7513_I2C_ARB_TIMEOUT_EN undefined: no counter; S_WAIT waits indefinitely; timeout_err is tied 0.
// STRUCTURE
//  Package adv7513_i2c_pkg holds:
//   - state encodings S_IDLE/S_ISSUE/S_WAIT/S_DONE/S_GAP (3-bit);
//   - CHIP_ADDR_W=7, REG_ADDR_W=8, DATA_W=8, STATUS_W=3, ST_TIMEOUT=3'b111.
//  Sub-module adv7513_rr_pick: combinational round-robin picker (req, rr_ptr -> one-hot grant and index).
//  The FSM, latches, gap counter and watchdog live in this module. The state register uses safe encoding.
// TESTING
//  1 Single write: req=3'b001, rnw=0, chip 0x39, reg 0x41, data 0x10 -> m_write_en 1 cycle; m_* = 0x39/0x41/0x10; ack[0] 1 cycle after busy falls.
//  2 Single read: req[1], reg 0x42, model returns 0x60 -> m_read_en once; rdata=0x60 and status=m_status in the ack cycle.
//  3 Contention: req=3'b111 held -> grant order 0,1,2,0; each gnt is one-hot; rr_ptr rotates.
//  4 Gap: TXN_GAP=4, two queued requests -> exactly 5 cycles from ack to the next gnt rising; late busy rise (+1 cycle) does not end S_WAIT early.
//  5 Reset mid-S_WAIT: reset=0 for 1 cycle -> all outputs 0; no ack; a fresh req restarts from requester 0.
//  6 Macro on, TIMEOUT_CYCLES=100, busy stuck high -> timeout_err and ack pulse after 100 cycles; status=3'b111; next requester granted.

Source files
------------

// File: rtl/adv7513_i2c_pkg.sv
// Shared types and widths for the ADV7513 I2C arbiter slice.
// State encoding and field widths used by the arbiter and its picker.
package adv7513_i2c_pkg;

  localparam int CHIP_ADDR_W = 7;
  localparam int REG_ADDR_W  = 8;
  localparam int DATA_W      = 8;
  localparam int STATUS_W    = 3;

  localparam logic [STATUS_W-1:0] ST_TIMEOUT = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

endpackage

// File: rtl/adv7513_rr_pick.sv
// Combinational round-robin picker: first set request
// scanning upward from ptr+1, wrapping modulo NUM_REQ.
module adv7513_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic [IW-1:0]      idx
);

  logic [IW-1:0] j;

  // Scan from the far end so the nearest candidate wins last.
  always_comb begin
    onehot = '0;
    idx    = '0;
    j      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = IW'((int'(ptr) + k) % NUM_REQ);
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = j;
      end
    end
  end

endmodule

// File: rtl/adv7513_i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NUM_REQ requesters.
// Optional S_WAIT watchdog: define ADV7513_I2C_ARB_TIMEOUT_EN.
module adv7513_i2c_arbiter
  import adv7513_i2c_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TXN_GAP        = 0,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       rnw,
  input  logic [7*NUM_REQ-1:0]     chip_addr_in,
  input  logic [8*NUM_REQ-1:0]     reg_addr_in,
  input  logic [8*NUM_REQ-1:0]     wdata_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [DATA_W-1:0]        rdata,
  output logic [STATUS_W-1:0]      status,
  output logic                     timeout_err,
  output logic [CHIP_ADDR_W-1:0]   m_chip_addr,
  output logic [REG_ADDR_W-1:0]    m_reg_addr,
  output logic [DATA_W-1:0]        m_data_in,
  output logic                     m_write_en,
  output logic                     m_read_en,
  input  logic                     m_busy,
  input  logic [DATA_W-1:0]        m_data_out,
  input  logic [STATUS_W-1:0]      m_status
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                 state;
  logic [IW-1:0]          rr_ptr;
  logic [IW-1:0]          g_idx;
  logic                   rnw_l;
  logic [15:0]            gap_cnt;
  logic [NUM_REQ-1:0]     pick;
  logic [IW-1:0]          pick_idx;
  logic [CHIP_ADDR_W-1:0] sel_chip;
  logic [REG_ADDR_W-1:0]  sel_reg;
  logic [DATA_W-1:0]      sel_wd;
  logic                   sel_rnw;

  adv7513_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .onehot (pick),
    .idx    (pick_idx)
  );

  always_comb begin
    sel_chip = '0;
    sel_reg  = '0;
    sel_wd   = '0;
    sel_rnw  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick[i]) begin
        sel_chip = chip_addr_in[i*CHIP_ADDR_W +: CHIP_ADDR_W];
        sel_reg  = reg_addr_in[i*REG_ADDR_W +: REG_ADDR_W];
        sel_wd   = wdata_in[i*DATA_W +: DATA_W];
        sel_rnw  = rnw[i];
      end
    end
  end

`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
  logic [25:0] wd_cnt;
`else
  assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      rr_ptr      <= IW'(NUM_REQ-1);
      g_idx       <= '0;
      rnw_l       <= 1'b0;
      gap_cnt     <= '0;
      gnt         <= '0;
      ack         <= '0;
      rdata       <= '0;
      status      <= '0;
      m_chip_addr <= '0;
      m_reg_addr  <= '0;
      m_data_in   <= '0;
      m_write_en  <= 1'b0;
      m_read_en   <= 1'b0;
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      ack        <= '0;
      m_write_en <= 1'b0;
      m_read_en  <= 1'b0;
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt         <= pick;
            g_idx       <= pick_idx;
            rnw_l       <= sel_rnw;
            m_chip_addr <= sel_chip;
            m_reg_addr  <= sel_reg;
            m_data_in   <= sel_wd;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          m_read_en  <= rnw_l;
          m_write_en <= !rnw_l;
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
          wd_cnt     <= '0;
`endif
          state      <= S_WAIT;
        end
        // Strobe term keeps us here if busy rises one cycle late.
        S_WAIT: begin
          if (!m_write_en && !m_read_en && !m_busy) begin
            ack    <= gnt;
            status <= m_status;
            if (rnw_l) rdata <= m_data_out;
            state  <= S_DONE;
          end
`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
          else if (wd_cnt == 26'(TIMEOUT_CYCLES-1)) begin
            ack         <= gnt;
            timeout_err <= 1'b1;
            status      <= ST_TIMEOUT;
            rr_ptr      <= g_idx;
            gap_cnt     <= 16'(TXN_GAP);
            state       <= S_GAP;
          end else begin
            wd_cnt <= wd_cnt + 26'd1;
          end
`endif
        end
        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= g_idx;
          if (TXN_GAP == 0) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= 16'(TXN_GAP-1);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          gnt <= '0;
          if (gap_cnt == 16'd0) state <= S_IDLE;
          else gap_cnt <= gap_cnt - 16'd1;
        end
        default: begin
          gnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adv7513_i2c_arbiter.sv
// Scoreboard bench for adv7513_i2c_arbiter with an i2c_master model.
// Define ADV7513_I2C_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_adv7513_i2c_arbiter;

  localparam int N   = 3;
  localparam int GAP = 4;
  localparam int TO  = 100;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req, rnw, gnt, ack;
  logic [7*N-1:0] chip_addr_in;
  logic [8*N-1:0] reg_addr_in, wdata_in;
  logic [7:0]   rdata, m_reg_addr, m_data_in, m_data_out;
  logic [2:0]   status, m_status;
  logic [6:0]   m_chip_addr;
  logic         timeout_err, m_write_en, m_read_en, m_busy;

  always #5 clk = ~clk;

  adv7513_i2c_arbiter #(
    .NUM_REQ        (N),
    .TXN_GAP        (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .rnw          (rnw),
    .chip_addr_in (chip_addr_in),
    .reg_addr_in  (reg_addr_in),
    .wdata_in     (wdata_in),
    .gnt          (gnt),
    .ack          (ack),
    .rdata        (rdata),
    .status       (status),
    .timeout_err  (timeout_err),
    .m_chip_addr  (m_chip_addr),
    .m_reg_addr   (m_reg_addr),
    .m_data_in    (m_data_in),
    .m_write_en   (m_write_en),
    .m_read_en    (m_read_en),
    .m_busy       (m_busy),
    .m_data_out   (m_data_out),
    .m_status     (m_status)
  );

  typedef struct {
    int         idx;
    logic       rnw;
    logic [6:0] chip;
    logic [7:0] rg;
    logic [7:0] wd;
    bit         to;
  } txn_t;

  txn_t       sb_q[$];
  int         grant_log[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem_m[256];
  logic [7:0] ref_mem[256];
  logic [7:0] exp_rdata;
  logic [2:0] cur_status = 3'd0;
  bit         busy_stuck = 1'b0;
  int         busy_len_ovr = 0;
  int         ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int find_sb(input int idx);
    foreach (sb_q[p]) if (sb_q[p].idx == idx) return p;
    return -1;
  endfunction

  // i2c_master model: busy rises same or next cycle, falls after len.
  initial begin
    m_busy = 1'b0;
    m_data_out = '0;
    m_status = '0;
    forever begin
      @(posedge clk); #1;
      if (reset && (m_write_en || m_read_en)) begin
        automatic bit rd = m_read_en;
        automatic logic [7:0] ra = m_reg_addr;
        automatic int late = $urandom_range(0, 1);
        automatic int len = (busy_len_ovr > 0) ? busy_len_ovr
                                               : $urandom_range(1, 5);
        if (!rd) mem_m[ra] = m_data_in;
        if (late != 0) begin @(posedge clk); #1; end
        m_busy = 1'b1;
        repeat (len) begin @(posedge clk); #1; end
        while (busy_stuck) begin @(posedge clk); #1; end
        if (rd) m_data_out = mem_m[ra];
        m_status = 3'($urandom_range(0, 6));
        cur_status = m_status;
        m_busy = 1'b0;
      end
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  logic [N-1:0] req_prev, gnt_prev;
  int  lp, strobe_cnt, low_cnt, since_strobe, e, g, p;
  bit  track, pend, busy_prev, busy_fell;

  always @(negedge clk) begin
    if (!reset) begin
      lp = N - 1;
      sb_q.delete();
      track = 0;
      strobe_cnt = 0;
      exp_rdata = '0;
      busy_prev = m_busy;
      busy_fell = 0;
      req_prev = req;
      gnt_prev = '0;
    end else begin
      if (gnt != '0 && gnt_prev == '0) begin
        e = -1;
        for (int k = 1; k <= N; k++)
          if (e < 0 && req_prev[(lp + k) % N]) e = (lp + k) % N;
        chk("grant", 32'(gnt), (e >= 0) ? 32'(1 << e) : 32'd0);
        if (track) begin
          if (pend) chk("gap_exact", low_cnt, GAP + 1);
          else chk("gap_min", 32'(low_cnt >= GAP + 1), 1);
          track = 0;
        end
        if (e >= 0) begin
          lp = e;
          grant_log.push_back(e);
        end
        strobe_cnt = 0;
      end
      if (m_write_en || m_read_en) begin
        strobe_cnt++;
        since_strobe = 0;
        chk("strobe_excl", 32'(m_write_en & m_read_en), 0);
        chk("strobe_once", strobe_cnt, 1);
        g = oh2i(gnt);
        p = find_sb(g);
        chk("strobe_owner", 32'(p >= 0), 1);
        if (p >= 0) begin
          chk("m_read_en", 32'(m_read_en), 32'(sb_q[p].rnw));
          chk("m_chip", 32'(m_chip_addr), 32'(sb_q[p].chip));
          chk("m_reg", 32'(m_reg_addr), 32'(sb_q[p].rg));
          if (!sb_q[p].rnw)
            chk("m_data_in", 32'(m_data_in), 32'(sb_q[p].wd));
        end
      end else begin
        since_strobe++;
      end
      if (ack != '0) begin
        ack_cnt++;
        chk("ack_onehot", $countones(ack), 1);
        chk("ack_gnt", 32'(ack), 32'(gnt));
        p = find_sb(oh2i(ack));
        chk("ack_owner", 32'(p >= 0), 1);
        if (p >= 0) begin
          if (sb_q[p].to) begin
            chk("to_err", 32'(timeout_err), 1);
            chk("to_status", 32'(status), 32'h7);
            chk("to_cycles", since_strobe, TO);
          end else begin
            chk("to_err_idle", 32'(timeout_err), 0);
            chk("ack_after_busy", 32'(busy_fell), 1);
            chk("status", 32'(status), 32'(cur_status));
            if (sb_q[p].rnw) exp_rdata = ref_mem[sb_q[p].rg];
            else ref_mem[sb_q[p].rg] = sb_q[p].wd;
          end
          chk("rdata", 32'(rdata), 32'(exp_rdata));
          sb_q.delete(p);
        end
        track = 1;
        low_cnt = 0;
        pend = (req & ~ack) != '0;
      end else begin
        if (timeout_err) chk("stray_timeout", 32'(timeout_err), 0);
        if (track && gnt == '0) low_cnt++;
      end
      busy_fell = busy_prev && !m_busy;
      busy_prev = m_busy;
      req_prev = req;
      gnt_prev = gnt;
    end
  end

  task automatic do_req(input int i, input bit r, input logic [6:0] c,
                        input logic [7:0] a, input logic [7:0] d,
                        input bit to, input int limit);
    txn_t t;
    bit scr = 0;
    t.idx = i; t.rnw = r; t.chip = c; t.rg = a; t.wd = d; t.to = to;
    sb_q.push_back(t);
    rnw[i] = r;
    chip_addr_in[7*i +: 7] = c;
    reg_addr_in[8*i +: 8] = a;
    wdata_in[8*i +: 8] = d;
    req[i] = 1'b1;
    for (int n = 0; n < limit; n++) begin
      @(posedge clk); #1;
      if (gnt[i] && !scr) begin
        // Post-grant input changes must not reach the master.
        rnw[i] = ~r;
        chip_addr_in[7*i +: 7] = ~c;
        reg_addr_in[8*i +: 8] = ~a;
        wdata_in[8*i +: 8] = ~d;
        scr = 1;
      end
      if (ack[i]) begin
        req[i] = 1'b0;
        return;
      end
    end
    chk("ack_wait", 0, 1);
    req[i] = 1'b0;
  endtask

  task automatic rand_seq(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      int d;
      d = $urandom_range(0, 3);
      repeat (d) begin @(posedge clk); #1; end
      do_req(i, 1'($urandom_range(0, 1)), 7'($urandom),
             8'($urandom_range(0, 7)), 8'($urandom), 0, 300);
    end
  endtask

  task automatic wait_idle_master();
    for (int n = 0; n < 200 && m_busy; n++) begin
      @(posedge clk); #1;
    end
    chk("master_idle", 32'(m_busy), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sz;
    int snap;
    reset = 1'b0;
    req = '0; rnw = '0;
    chip_addr_in = '0; reg_addr_in = '0; wdata_in = '0;
    for (int i = 0; i < 256; i++) begin
      mem_m[i] = 8'(i) ^ 8'h5a;
      ref_mem[i] = 8'(i) ^ 8'h5a;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {gnt, ack, rdata, status, timeout_err,
                     m_write_en, m_read_en}, 0);
    chk("rst_maddr", {m_chip_addr, m_reg_addr, m_data_in}, 0);
    reset = 1'b1;

    // Contention: all three held, two transactions each.
    fork
      begin for (int k = 0; k < 2; k++)
        do_req(0, 0, 7'h39, 8'h10, 8'(k), 0, 300); end
      begin for (int k = 0; k < 2; k++)
        do_req(1, 0, 7'h39, 8'h11, 8'(k), 0, 300); end
      begin for (int k = 0; k < 2; k++)
        do_req(2, 0, 7'h39, 8'h12, 8'(k), 0, 300); end
    join
    chk("log_size", 32'(grant_log.size() >= 4), 1);
    if (grant_log.size() >= 4) begin
      chk("order0", grant_log[0], 0);
      chk("order1", grant_log[1], 1);
      chk("order2", grant_log[2], 2);
      chk("order3", grant_log[3], 0);
    end

    // Single write, then single read of a preloaded register.
    do_req(0, 0, 7'h39, 8'h41, 8'h10, 0, 300);
    chk("w_chip", 32'(m_chip_addr), 32'h39);
    chk("w_reg", 32'(m_reg_addr), 32'h41);
    chk("w_data", 32'(m_data_in), 32'h10);
    mem_m[8'h42] = 8'h60;
    ref_mem[8'h42] = 8'h60;
    do_req(1, 1, 7'h39, 8'h42, 8'h00, 0, 300);
    chk("r_rdata", 32'(rdata), 32'h60);
    chk("r_status", 32'(status), 32'(cur_status));

    fork
      rand_seq(0, 8);
      rand_seq(1, 8);
      rand_seq(2, 8);
    join

    // Reset while the arbiter waits on busy.
    busy_len_ovr = 20;
    begin
      txn_t t;
      t.idx = 1; t.rnw = 1; t.chip = 7'h39; t.rg = 8'h05;
      t.wd = 8'h00; t.to = 0;
      sb_q.push_back(t);
    end
    rnw[1] = 1'b1;
    chip_addr_in[7 +: 7] = 7'h39;
    reg_addr_in[8 +: 8] = 8'h05;
    req[1] = 1'b1;
    for (int n = 0; n < 50 && !(m_write_en || m_read_en); n++) begin
      @(posedge clk); #1;
    end
    chk("rst_strobe_seen", 32'(m_read_en), 1);
    repeat (2) begin @(posedge clk); #1; end
    snap = ack_cnt;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outs", {gnt, ack, rdata, status, timeout_err,
                        m_write_en, m_read_en}, 0);
    chk("midrst_maddr", {m_chip_addr, m_reg_addr, m_data_in}, 0);
    reset = 1'b1;
    req[1] = 1'b0;
    wait_idle_master();
    repeat (3) begin @(posedge clk); #1; end
    chk("midrst_noack", ack_cnt, snap);
    busy_len_ovr = 0;
    sz = grant_log.size();
    fork
      do_req(0, 0, 7'h20, 8'h30, 8'h31, 0, 300);
      do_req(1, 0, 7'h20, 8'h32, 8'h33, 0, 300);
      do_req(2, 0, 7'h20, 8'h34, 8'h35, 0, 300);
    join
    chk("post_rst_first", (grant_log.size() > sz) ? grant_log[sz] : -1, 0);

`ifdef ADV7513_I2C_ARB_TIMEOUT_EN
    busy_stuck = 1'b1;
    snap = int'(rdata);
    do_req(0, 1, 7'h39, 8'h06, 8'h00, 1, 400);
    chk("to_status_hold", 32'(status), 32'h7);
    chk("to_rdata_hold", 32'(rdata), 32'(snap));
    busy_stuck = 1'b0;
    wait_idle_master();
    sz = grant_log.size();
    fork
      do_req(0, 0, 7'h39, 8'h07, 8'h44, 0, 300);
      do_req(1, 0, 7'h39, 8'h08, 8'h55, 0, 300);
    join
    chk("to_next_req", (grant_log.size() > sz) ? grant_log[sz] : -1, 1);
`endif

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
